kernel_loop_ctrl: RTL and testbench

- Sequencing controller that sits directly upstream of a mapped loop kernel in the CGRA fabric.
- Drives the kernel's shared `global_en`/`global_rst` nets, which feed every `reg_unit` and memory reset.
- Consumes the kernel's loop-branch result (the 1-bit compare → branch output) to decide when the loop exits.
- Sequence per run: clear the pipeline, run iterations, drain in-flight results, report completion to the host/IO side.

---
 rtl/kernel_loop_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_kernel_loop_ctrl.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_loop_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_loop_ctrl
//
// Sequencing controller placed directly upstream of a mapped loop kernel in the
// CGRA fabric. One run is: clear the kernel pipeline (global_rst), run loop
// iterations until the kernel's branch result says "exit", drain the in-flight
// results, then report completion.
//
// Optional feature:
//   KERNEL_LOOP_CTRL_WATCHDOG_EN - when defined, a run whose iteration count
//   reaches MAX_ITER without exiting is cancelled (aborted + timeout pulse).
//   When undefined there is no watchdog logic and timeout is tied low.
//
// Ports:
//   UserCLK     in   fabric user clock
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle request to begin a kernel run (IDLE only)
//   abort       in   cancel the current run (CLEAR/RUN/DRAIN)
//   stall       in   back-pressure; freezes the kernel in RUN/DRAIN
//   loop_cond   in   kernel branch result: 1 = continue, 0 = exit
//   global_en   out  kernel-wide register enable
//   global_rst  out  kernel-wide synchronous reset (active-high)
//   busy        out  high in CLEAR, RUN and DRAIN
//   done        out  one-cycle pulse on normal completion
//   aborted     out  one-cycle pulse when a run ends through abort/watchdog
//   timeout     out  one-cycle pulse on watchdog expiry
//   iter_count  out  enabled RUN cycles in the current/last run (saturating)
//
// Timing: every output is a flop computed from the next state, so an output
// reflects a decision made at the previous clock edge. In RUN/DRAIN, global_en
// for a cycle is ~stall as sampled at the edge that started the cycle, and
// iter_count is bumped together with it, so iter_count always equals the
// number of RUN cycles in which the kernel actually had global_en high.
// loop_cond and the warm-up/drain counters are evaluated at the end of each
// such enabled cycle.
// -----------------------------------------------------------------------------
module kernel_loop_ctrl #(
  parameter int unsigned       WIDTH        = 32,
  parameter int unsigned       CLEAR_CYCLES = 2,
  parameter int unsigned       COND_LATENCY = 3,
  parameter int unsigned       DRAIN_CYCLES = 8,
  parameter logic [WIDTH-1:0]  MAX_ITER     = {WIDTH{1'b1}}
) (
  input  logic             UserCLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  input  logic             loop_cond,
  output logic             global_en,
  output logic             global_rst,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             timeout,
  output logic [WIDTH-1:0] iter_count
);

  // Parameter sanity, evaluated at elaboration.
  if (CLEAR_CYCLES < 1) begin : g_chk_clear
    $error("kernel_loop_ctrl: CLEAR_CYCLES must be at least 1");
  end
  if (MAX_ITER == '0) begin : g_chk_max_iter
    $error("kernel_loop_ctrl: MAX_ITER must be non-zero");
  end

  // Counter widths; each counter counts 0 .. (limit - 1) or 0 .. limit.
  localparam int unsigned CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int unsigned WARM_W = (COND_LATENCY > 0) ? $clog2(COND_LATENCY + 1) : 1;
  localparam int unsigned DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e             state_q,      state_d;
  logic [CLR_W-1:0]   clear_cnt_q,  clear_cnt_d;
  logic [WARM_W-1:0]  warm_cnt_q,   warm_cnt_d;
  logic [DRN_W-1:0]   drain_cnt_q,  drain_cnt_d;
  logic [WIDTH-1:0]   iter_count_q, iter_count_d;
  logic               global_en_q,  global_en_d;
  logic               global_rst_q, global_rst_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic               aborted_q,    aborted_d;
`ifdef KERNEL_LOOP_CTRL_WATCHDOG_EN
  logic               timeout_q,    timeout_d;
`endif

  logic clear_last;
  logic warm_done;
  logic drain_last;
  logic in_run_phase;

  assign clear_last   = (clear_cnt_q == CLR_W'(CLEAR_CYCLES - 1));
  assign warm_done    = (warm_cnt_q  == WARM_W'(COND_LATENCY));
  // Unreachable when DRAIN_CYCLES == 0: RUN then goes straight to DONE.
  assign drain_last   = (drain_cnt_q == DRN_W'(DRAIN_CYCLES - 1));
  assign in_run_phase = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                        (state_q == ST_DRAIN);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    clear_cnt_d  = clear_cnt_q;
    warm_cnt_d   = warm_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    iter_count_d = iter_count_q;
    aborted_d    = 1'b0;
`ifdef KERNEL_LOOP_CTRL_WATCHDOG_EN
    timeout_d    = 1'b0;
`endif

    if (in_run_phase && abort) begin
      // Abort wins over everything else while a run is active.
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // start together with abort is treated as a cancelled request.
          if (start && !abort) begin
            state_d      = ST_CLEAR;
            clear_cnt_d  = '0;
            iter_count_d = '0;
          end
        end

        ST_CLEAR: begin
          // stall is deliberately ignored: the reset must reach every reg_unit.
          if (clear_last) begin
            state_d    = ST_RUN;
            warm_cnt_d = '0;
          end else begin
            clear_cnt_d = clear_cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          // Only a cycle the kernel actually executed advances the warm-up
          // count or produces a meaningful branch result.
          if (global_en_q) begin
            if (!warm_done) begin
              warm_cnt_d = warm_cnt_q + 1'b1;
            end
            if (warm_done && !loop_cond) begin
              state_d     = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_DONE;
              drain_cnt_d = '0;
            end
`ifdef KERNEL_LOOP_CTRL_WATCHDOG_EN
            // A genuine exit on the same cycle takes priority over the watchdog.
            else if (iter_count_q == MAX_ITER) begin
              state_d   = ST_IDLE;
              aborted_d = 1'b1;
              timeout_d = 1'b1;
            end
`endif
          end
        end

        ST_DRAIN: begin
          if (global_en_q) begin
            if (drain_last) begin
              state_d = ST_DONE;
            end else begin
              drain_cnt_d = drain_cnt_q + 1'b1;
            end
          end
        end

        ST_DONE: begin
          // start arriving here is dropped, not queued.
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are registered from the next state.
    global_rst_d = (state_d == ST_CLEAR);
    global_en_d  = (state_d == ST_CLEAR) ||
                   (((state_d == ST_RUN) || (state_d == ST_DRAIN)) && !stall);
    busy_d       = (state_d == ST_CLEAR) || (state_d == ST_RUN) ||
                   (state_d == ST_DRAIN);
    done_d       = (state_d == ST_DONE);

    // Count the RUN cycle being enabled now, saturating at all-ones.
    if ((state_d == ST_RUN) && !stall && (iter_count_d != {WIDTH{1'b1}})) begin
      iter_count_d = iter_count_d + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clear_cnt_q  <= '0;
      warm_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      iter_count_q <= '0;
      global_en_q  <= 1'b0;
      global_rst_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
`ifdef KERNEL_LOOP_CTRL_WATCHDOG_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      clear_cnt_q  <= clear_cnt_d;
      warm_cnt_q   <= warm_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      iter_count_q <= iter_count_d;
      global_en_q  <= global_en_d;
      global_rst_q <= global_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
`ifdef KERNEL_LOOP_CTRL_WATCHDOG_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign global_en  = global_en_q;
  assign global_rst = global_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign iter_count = iter_count_q;
`ifdef KERNEL_LOOP_CTRL_WATCHDOG_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_loop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kernel_loop_ctrl
//
// Bench for kernel_loop_ctrl with default parameters (MAX_ITER = 20 when the
// watchdog macro is defined). Stimulus is a per-cycle table of inputs; the
// table is applied and every output is recorded once per cycle. A behavioural
// model turns the same table into the expected per-cycle outputs.
//
// Cycle convention: the row for cycle c is driven at the falling edge inside
// cycle c and is sampled by the DUT at the rising edge ending cycle c, so its
// effect appears on the outputs recorded for cycle c+1.
// -----------------------------------------------------------------------------
module tb_kernel_loop_ctrl;

  localparam int CLEAR_CYCLES = 2;
  localparam int COND_LATENCY = 3;
  localparam int DRAIN_CYCLES = 8;
`ifdef KERNEL_LOOP_CTRL_WATCHDOG_EN
  localparam bit          WD_ON       = 1'b1;
  localparam logic [31:0] TB_MAX_ITER = 32'd20;
`else
  localparam bit          WD_ON       = 1'b0;
  localparam logic [31:0] TB_MAX_ITER = 32'hFFFF_FFFF;
`endif

  localparam int MAXC = 160;
  // Bit positions in a recorded output vector.
  localparam int B_EN = 5, B_RST = 4, B_BUSY = 3, B_DONE = 2, B_ABT = 1, B_TO = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, stall = 1'b0, loop_cond = 1'b0;
  logic        global_en, global_rst, busy, done, aborted, timeout;
  logic [31:0] iter_count;

  int n_run  = 0;
  int n_fail = 0;

  bit          s_start [MAXC];
  bit          s_abort [MAXC];
  bit          s_stall [MAXC];
  bit          s_cond  [MAXC];
  logic [5:0]  obs_vec [MAXC];
  logic [31:0] obs_iter[MAXC];
  logic [5:0]  exp_vec [MAXC];
  logic [31:0] exp_iter[MAXC];

  always #5 clk = ~clk;

  kernel_loop_ctrl #(
    .WIDTH       (32),
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .COND_LATENCY(COND_LATENCY),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .MAX_ITER    (TB_MAX_ITER)
  ) dut (
    .UserCLK   (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .stall     (stall),
    .loop_cond (loop_cond),
    .global_en (global_en),
    .global_rst(global_rst),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .timeout   (timeout),
    .iter_count(iter_count)
  );

  initial begin
    #500000;
    $display("FAIL global_time_limit: got still running, expected finished");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Stimulus infrastructure
  // ---------------------------------------------------------------------------
  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      s_start[c] = 1'b0;
      s_abort[c] = 1'b0;
      s_stall[c] = 1'b0;
      s_cond[c]  = 1'b1;
    end
  endtask

  task automatic drive_zero();
    start = 1'b0; abort = 1'b0; stall = 1'b0; loop_cond = 1'b0;
  endtask

  // Apply the stimulus table for n cycles and record the outputs of each cycle.
  task automatic run_trace(input int n, input bit do_reset);
    if (do_reset) begin
      rst_n = 1'b0;
      drive_zero();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      obs_vec[c]  = {global_en, global_rst, busy, done, aborted, timeout};
      obs_iter[c] = iter_count;
      start     = s_start[c];
      abort     = s_abort[c];
      stall     = s_stall[c];
      loop_cond = s_cond[c];
    end
  endtask

  // Reference model: walks the run phases as the controller's behaviour is
  // described (clear for a fixed number of cycles, iterate until an unmasked
  // exit, drain a fixed number of executed cycles, one done cycle), starting
  // from the post-reset idle condition.
  task automatic model_trace(input int n);
    int          phase;        // 0 idle, 1 clear, 2 run, 3 drain, 4 done
    int          nxt;
    int          clear_left;
    int          executed;     // executed RUN cycles since RUN entry
    int          drained;
    bit          en;
    bit          ab, to;
    logic [31:0] iters;
    phase = 0; en = 1'b0; iters = '0;
    clear_left = 0; executed = 0; drained = 0;
    exp_vec[0]  = '0;
    exp_iter[0] = '0;
    for (int c = 0; c < n - 1; c++) begin
      ab = 1'b0; to = 1'b0;
      nxt = phase;
      if (phase == 0) begin
        if (s_start[c] && !s_abort[c]) begin
          nxt = 1; clear_left = CLEAR_CYCLES; iters = '0;
        end
      end else if (phase == 4) begin
        nxt = 0;
      end else if (s_abort[c]) begin
        nxt = 0; ab = 1'b1;
      end else if (phase == 1) begin
        clear_left = clear_left - 1;
        if (clear_left == 0) begin
          nxt = 2; executed = 0;
        end
      end else if (phase == 2) begin
        if (en) begin
          executed = executed + 1;
          if (executed > COND_LATENCY && !s_cond[c]) begin
            nxt = (DRAIN_CYCLES > 0) ? 3 : 4; drained = 0;
          end else if (WD_ON && iters == TB_MAX_ITER) begin
            nxt = 0; ab = 1'b1; to = 1'b1;
          end
        end
      end else begin
        if (en) begin
          drained = drained + 1;
          if (drained == DRAIN_CYCLES) nxt = 4;
        end
      end
      phase = nxt;
      en = (phase == 1) || ((phase == 2 || phase == 3) && !s_stall[c]);
      if (phase == 2 && en && iters != 32'hFFFF_FFFF) iters = iters + 1;
      exp_vec[c+1]  = {en, phase == 1, phase >= 1 && phase <= 3, phase == 4, ab, to};
      exp_iter[c+1] = iters;
    end
  endtask

  function automatic int count_high(input int b, input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (obs_vec[c][b] === 1'b1) k++;
    return k;
  endfunction

  function automatic int first_high(input int b, input int n);
    for (int c = 0; c < n; c++) if (obs_vec[c][b] === 1'b1) return c;
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_zero();
    repeat (2) @(negedge clk);
    n_run++;
    if ({global_en, global_rst, busy, done, aborted, timeout, iter_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b iter=%0d, expected all zero",
               {global_en, global_rst, busy, done, aborted, timeout}, iter_count);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_run++;
    if ({global_en, global_rst, busy, done, aborted, timeout, iter_count} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b iter=%0d, expected all zero",
               {global_en, global_rst, busy, done, aborted, timeout}, iter_count);
    end
  endtask

  // Start at cycle 1: CLEAR 2..3, RUN 4..13, exit sampled at cycle 13
  // (10th RUN cycle), DRAIN 14..21, DONE at 22.
  task automatic test_basic_run();
    int bad, k;
    clear_stim();
    s_start[1] = 1'b1;
    s_cond[13] = 1'b0;
    run_trace(30, 1'b1);
    model_trace(30);
    bad = -1;
    for (int c = 0; c < 30; c++)
      if (bad < 0 && (obs_vec[c] !== exp_vec[c] || obs_iter[c] !== exp_iter[c])) bad = c;
    n_run++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL basic_trace cycle %0d: got %b iter=%0d, expected %b iter=%0d",
               bad, obs_vec[bad], obs_iter[bad], exp_vec[bad], exp_iter[bad]);
    end
    k = count_high(B_RST, 30);
    n_run++;
    if (k !== CLEAR_CYCLES) begin
      n_fail++; $display("FAIL basic_rst_cycles: got %0d, expected %0d", k, CLEAR_CYCLES);
    end
    k = count_high(B_EN, 30);
    n_run++;
    if (k !== CLEAR_CYCLES + 10 + DRAIN_CYCLES) begin
      n_fail++; $display("FAIL basic_en_cycles: got %0d, expected %0d", k, CLEAR_CYCLES + 18);
    end
    k = first_high(B_DONE, 30);
    n_run++;
    if (k !== 22 || count_high(B_DONE, 30) !== 1) begin
      n_fail++; $display("FAIL basic_done: got first=%0d count=%0d, expected first=22 count=1",
                         k, count_high(B_DONE, 30));
    end
    n_run++;
    if (obs_iter[29] !== 32'd10) begin
      n_fail++; $display("FAIL basic_iter: got %0d, expected 10", obs_iter[29]);
    end
  endtask

  // Stall held for 4 cycles in RUN and 3 in DRAIN; the kernel freezes on the
  // cycle after each stalled sample. The 10th executed RUN cycle is cycle 17.
  task automatic test_stall();
    int bad, k;
    clear_stim();
    s_start[1] = 1'b1;
    for (int c = 6; c <= 9; c++) s_stall[c] = 1'b1;
    s_cond[17] = 1'b0;
    for (int c = 19; c <= 21; c++) s_stall[c] = 1'b1;
    run_trace(40, 1'b1);
    model_trace(40);
    bad = -1;
    for (int c = 0; c < 40; c++)
      if (bad < 0 && (obs_vec[c] !== exp_vec[c] || obs_iter[c] !== exp_iter[c])) bad = c;
    n_run++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL stall_trace cycle %0d: got %b iter=%0d, expected %b iter=%0d",
               bad, obs_vec[bad], obs_iter[bad], exp_vec[bad], exp_iter[bad]);
    end
    k = 0;
    for (int c = 0; c < 40; c++) if (obs_vec[c][B_BUSY] === 1'b1 && obs_vec[c][B_EN] === 1'b0) k++;
    n_run++;
    if (k !== 7) begin
      n_fail++; $display("FAIL stall_low_en_cycles: got %0d, expected 7", k);
    end
    k = first_high(B_DONE, 40);
    n_run++;
    if (k !== 29) begin
      n_fail++; $display("FAIL stall_done_cycle: got %0d, expected 29", k);
    end
    n_run++;
    if (obs_iter[39] !== 32'd10) begin
      n_fail++; $display("FAIL stall_iter: got %0d, expected 10", obs_iter[39]);
    end
  endtask

  // loop_cond low from the very start: the exit is taken on the first
  // unmasked cycle (cycle 7), DRAIN 8..15, DONE at 16.
  task automatic test_warmup_mask();
    int bad, k;
    clear_stim();
    s_start[1] = 1'b1;
    for (int c = 0; c < MAXC; c++) s_cond[c] = 1'b0;
    run_trace(24, 1'b1);
    model_trace(24);
    bad = -1;
    for (int c = 0; c < 24; c++)
      if (bad < 0 && (obs_vec[c] !== exp_vec[c] || obs_iter[c] !== exp_iter[c])) bad = c;
    n_run++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL warmup_trace cycle %0d: got %b iter=%0d, expected %b iter=%0d",
               bad, obs_vec[bad], obs_iter[bad], exp_vec[bad], exp_iter[bad]);
    end
    n_run++;
    if (obs_iter[23] !== COND_LATENCY + 1) begin
      n_fail++; $display("FAIL warmup_iter: got %0d, expected %0d", obs_iter[23], COND_LATENCY + 1);
    end
    k = first_high(B_DONE, 24);
    n_run++;
    if (k !== 16) begin
      n_fail++; $display("FAIL warmup_done_cycle: got %0d, expected 16", k);
    end
  endtask

  // abort sampled at the end of the 5th RUN cycle (cycle 8).
  task automatic test_abort();
    int bad, k;
    clear_stim();
    s_start[1] = 1'b1;
    s_abort[8] = 1'b1;
    run_trace(20, 1'b1);
    model_trace(20);
    bad = -1;
    for (int c = 0; c < 20; c++)
      if (bad < 0 && (obs_vec[c] !== exp_vec[c] || obs_iter[c] !== exp_iter[c])) bad = c;
    n_run++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL abort_trace cycle %0d: got %b iter=%0d, expected %b iter=%0d",
               bad, obs_vec[bad], obs_iter[bad], exp_vec[bad], exp_iter[bad]);
    end
    k = first_high(B_ABT, 20);
    n_run++;
    if (k !== 9 || count_high(B_ABT, 20) !== 1 || obs_vec[9][B_EN] !== 1'b0) begin
      n_fail++; $display("FAIL abort_pulse: got first=%0d count=%0d en=%b, expected first=9 count=1 en=0",
                         k, count_high(B_ABT, 20), obs_vec[9][B_EN]);
    end
    n_run++;
    if (count_high(B_DONE, 20) !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d done pulses, expected 0", count_high(B_DONE, 20));
    end
    n_run++;
    if (obs_iter[19] !== 32'd5) begin
      n_fail++; $display("FAIL abort_iter: got %0d, expected 5", obs_iter[19]);
    end
  endtask

  // start during RUN and during DONE is dropped; start+abort in IDLE and a
  // lone abort in IDLE do nothing.
  task automatic test_collisions();
    int bad;
    clear_stim();
    s_start[1]  = 1'b1;
    s_start[6]  = 1'b1;
    s_cond[13]  = 1'b0;
    s_start[22] = 1'b1;
    s_start[26] = 1'b1;
    s_abort[26] = 1'b1;
    s_abort[28] = 1'b1;
    run_trace(32, 1'b1);
    model_trace(32);
    bad = -1;
    for (int c = 0; c < 32; c++)
      if (bad < 0 && (obs_vec[c] !== exp_vec[c] || obs_iter[c] !== exp_iter[c])) bad = c;
    n_run++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL collide_trace cycle %0d: got %b iter=%0d, expected %b iter=%0d",
               bad, obs_vec[bad], obs_iter[bad], exp_vec[bad], exp_iter[bad]);
    end
    n_run++;
    if (count_high(B_BUSY, 32) !== CLEAR_CYCLES + 10 + DRAIN_CYCLES || first_high(B_DONE, 32) !== 22) begin
      n_fail++; $display("FAIL collide_single_run: got busy=%0d done_at=%0d, expected busy=20 done_at=22",
                         count_high(B_BUSY, 32), first_high(B_DONE, 32));
    end
    n_run++;
    if (obs_vec[27] !== 6'b0 || obs_vec[31] !== 6'b0 || count_high(B_ABT, 32) !== 0) begin
      n_fail++; $display("FAIL collide_idle: got c27=%b c31=%b aborted=%0d, expected zeros",
                         obs_vec[27], obs_vec[31], count_high(B_ABT, 32));
    end
  endtask

  // Reset pulled low in the middle of DRAIN, then a fresh run.
  task automatic test_reset_mid_drain();
    int bad;
    clear_stim();
    s_start[1] = 1'b1;
    s_cond[13] = 1'b0;
    run_trace(18, 1'b1);          // ends inside cycle 17, a DRAIN cycle
    n_run++;
    if (busy !== 1'b1 || iter_count !== 32'd10) begin
      n_fail++; $display("FAIL pre_reset_drain: got busy=%b iter=%0d, expected busy=1 iter=10",
                         busy, iter_count);
    end
    #2;
    rst_n = 1'b0;
    drive_zero();
    #1;
    n_run++;
    if ({global_en, global_rst, busy, done, aborted, timeout, iter_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b iter=%0d, expected all zero",
               {global_en, global_rst, busy, done, aborted, timeout}, iter_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_trace(30, 1'b0);
    model_trace(30);
    bad = -1;
    for (int c = 0; c < 30; c++)
      if (bad < 0 && (obs_vec[c] !== exp_vec[c] || obs_iter[c] !== exp_iter[c])) bad = c;
    n_run++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL rerun_trace cycle %0d: got %b iter=%0d, expected %b iter=%0d",
               bad, obs_vec[bad], obs_iter[bad], exp_vec[bad], exp_iter[bad]);
    end
    n_run++;
    if (first_high(B_DONE, 30) !== 22 || obs_iter[29] !== 32'd10) begin
      n_fail++; $display("FAIL rerun_done: got done_at=%0d iter=%0d, expected done_at=22 iter=10",
                         first_high(B_DONE, 30), obs_iter[29]);
    end
  endtask

  // loop_cond held at 1 for the whole run.
  task automatic test_watchdog();
    int bad;
    clear_stim();
    s_start[1] = 1'b1;
    run_trace(60, 1'b1);
    model_trace(60);
    bad = -1;
    for (int c = 0; c < 60; c++)
      if (bad < 0 && (obs_vec[c] !== exp_vec[c] || obs_iter[c] !== exp_iter[c])) bad = c;
    n_run++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL watchdog_trace cycle %0d: got %b iter=%0d, expected %b iter=%0d",
               bad, obs_vec[bad], obs_iter[bad], exp_vec[bad], exp_iter[bad]);
    end
`ifdef KERNEL_LOOP_CTRL_WATCHDOG_EN
    // 20th executed RUN cycle is cycle 23; the expiry shows at cycle 24.
    n_run++;
    if (first_high(B_TO, 60) !== 24 || count_high(B_TO, 60) !== 1 ||
        obs_vec[24][B_ABT] !== 1'b1 || count_high(B_ABT, 60) !== 1) begin
      n_fail++; $display("FAIL watchdog_pulses: got to_at=%0d to_n=%0d ab_n=%0d, expected 24/1/1",
                         first_high(B_TO, 60), count_high(B_TO, 60), count_high(B_ABT, 60));
    end
    n_run++;
    if (obs_iter[59] !== 32'd20 || count_high(B_DONE, 60) !== 0) begin
      n_fail++; $display("FAIL watchdog_iter: got iter=%0d done=%0d, expected iter=20 done=0",
                         obs_iter[59], count_high(B_DONE, 60));
    end
`else
    n_run++;
    if (count_high(B_TO, 60) !== 0 || obs_vec[59][B_BUSY] !== 1'b1) begin
      n_fail++; $display("FAIL no_watchdog: got timeout=%0d busy=%b, expected timeout=0 busy=1",
                         count_high(B_TO, 60), obs_vec[59][B_BUSY]);
    end
    n_run++;
    if (obs_iter[59] !== 32'd56) begin
      n_fail++; $display("FAIL no_watchdog_iter: got %0d, expected 56", obs_iter[59]);
    end
`endif
  endtask

  task automatic test_random();
    int bad;
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < MAXC; c++) begin
        s_start[c] = ($urandom_range(0, 15) == 0);
        s_abort[c] = ($urandom_range(0, 69) == 0);
        s_stall[c] = ($urandom_range(0, 3) == 0);
        s_cond[c]  = ($urandom_range(0, 11) != 0);
      end
      run_trace(150, 1'b1);
      model_trace(150);
      bad = -1;
      for (int c = 0; c < 150; c++)
        if (bad < 0 && (obs_vec[c] !== exp_vec[c] || obs_iter[c] !== exp_iter[c])) bad = c;
      n_run++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL random_%0d cycle %0d: got %b iter=%0d, expected %b iter=%0d",
                 r, bad, obs_vec[bad], obs_iter[bad], exp_vec[bad], exp_iter[bad]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_stall();
    test_warmup_mask();
    test_abort();
    test_collisions();
    test_reset_mid_drain();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
